// File: rtl/press_step_controller.sv
// Button sequencing controller: three raw buttons are synchronized, debounced and
// arbitrated into single-cycle increment/clear commands, with a divided-rate auto-run mode.
module press_step_controller #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      TICK_DIV   = 12_000_000,
    parameter int unsigned      DEB_CYCLES = 240_000,
    parameter logic [WIDTH-1:0] LIMIT      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             btn_clr,
    input  logic [WIDTH-1:0] count_i,
    output logic             inc_o,
    output logic             clr_o,
    output logic             running_o,
    output logic [1:0]       state_o
);

    localparam int unsigned     DEB_W     = $clog2(DEB_CYCLES + 1);
    localparam int unsigned     TICK_W    = $clog2(TICK_DIV);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Button index order used throughout: 0 = step, 1 = run, 2 = clear.
    logic [2:0]       w_btn;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_ev;
    logic [DEB_W-1:0] r_deb_cnt [3];

    assign w_btn = {btn_clr, btn_run, btn_step};

    // NOTE: raw buttons are asynchronous, so nothing reads them before the second flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_ev    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_ev[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                        r_ev[i]      <= r_sync2[i];
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    logic w_ev_step;
    logic w_ev_run;
    logic w_ev_clr;
    logic w_at_limit;
    logic w_tick_done;

    assign w_ev_step   = r_ev[0];
    assign w_ev_run    = r_ev[1];
    assign w_ev_clr    = r_ev[2];
    assign w_at_limit  = (count_i == LIMIT);

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic              r_inc;
    logic              r_clr;
    logic              r_running;

    assign w_tick_done = (r_tick == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_inc     <= 1'b0;
            r_clr     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            // NOTE: command outputs default low each cycle so every command is a one-clock pulse.
            r_inc <= 1'b0;
            r_clr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tick <= '0;
                    if (w_ev_clr) begin
                        r_state <= ST_CLEAR;
                        r_clr   <= 1'b1;
                    end else if (w_ev_run) begin
                        if (!w_at_limit) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end else if (w_ev_step) begin
                        r_inc <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ev_clr) begin
                        r_state   <= ST_CLEAR;
                        r_clr     <= 1'b1;
                        r_running <= 1'b0;
                        r_tick    <= '0;
                    end else if (w_ev_run) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        r_tick    <= '0;
                    end else if (w_tick_done) begin
                        r_tick <= '0;
                        // Auto-stop: never auto-increment a counter already sitting at LIMIT.
                        if (w_at_limit) begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end else begin
                            r_inc <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_IDLE;
                    r_tick  <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_tick    <= '0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign inc_o     = r_inc;
    assign clr_o     = r_clr;
    assign running_o = r_running;
    assign state_o   = r_state;

endmodule

// File: tb/tb_press_step_controller.sv
// Self-checking bench for press_step_controller: directed scenarios with literal
// expectations plus randomized button traffic compared against a behavioural model each cycle.
module tb_press_step_controller;

    localparam int         WIDTH    = 8;
    localparam int         TICK_DIV = 4;
    localparam int         DEB      = 3;
    localparam logic [7:0] LIMIT    = 8'd5;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_run  = 1'b0;
    logic       btn_clr  = 1'b0;
    logic [7:0] count;
    logic       inc_o;
    logic       clr_o;
    logic       running_o;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    press_step_controller #(
        .WIDTH     (WIDTH),
        .TICK_DIV  (TICK_DIV),
        .DEB_CYCLES(DEB),
        .LIMIT     (LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .btn_run  (btn_run),
        .btn_clr  (btn_clr),
        .count_i  (count),
        .inc_o    (inc_o),
        .clr_o    (clr_o),
        .running_o(running_o),
        .state_o  (state_o)
    );

    // External counter datapath driven by the controller's commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= '0;
        else if (clr_o) count <= '0;
        else if (inc_o) count <= count + 8'd1;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a button level flips once the last DEB synchronized samples
    // all disagree with it; auto-run ticks fire every TICK_DIV-th cycle spent in RUN.
    logic [DEB+1:0] m_hist [3];
    logic [2:0]     m_deb = '0;
    logic [2:0]     m_ev  = '0;
    int             m_state = 0;
    int             m_age   = 0;
    bit             m_inc   = 1'b0;
    bit             m_clr   = 1'b0;

    task automatic model_step();
        logic [2:0] b;
        logic [2:0] ev_now;
        bit         diff;
        b     = {btn_clr, btn_run, btn_step};
        m_inc = 1'b0;
        m_clr = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_deb   = '0;
            m_ev    = '0;
            m_state = 0;
            m_age   = 0;
            return;
        end
        ev_now = m_ev;
        case (m_state)
            0: begin
                if (ev_now[2]) begin
                    m_state = 2;
                    m_clr   = 1'b1;
                end else if (ev_now[1]) begin
                    if (count != LIMIT) begin
                        m_state = 1;
                        m_age   = 0;
                    end
                end else if (ev_now[0]) begin
                    m_inc = 1'b1;
                end
            end
            1: begin
                if (ev_now[2]) begin
                    m_state = 2;
                    m_clr   = 1'b1;
                end else if (ev_now[1]) begin
                    m_state = 0;
                end else begin
                    if (m_age % TICK_DIV == TICK_DIV - 1) begin
                        if (count == LIMIT) m_state = 0;
                        else                m_inc   = 1'b1;
                    end
                    m_age++;
                end
            end
            default: m_state = 0;
        endcase
        for (int i = 0; i < 3; i++) begin
            diff = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (m_hist[i][k] == m_deb[i]) diff = 1'b0;
            end
            m_ev[i] = 1'b0;
            if (diff) begin
                m_deb[i] = ~m_deb[i];
                m_ev[i]  = m_deb[i];
            end
            m_hist[i] = {m_hist[i][DEB:0], b[i]};
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("inc_o",     int'(inc_o),     int'(m_inc));
            check("clr_o",     int'(clr_o),     int'(m_clr));
            check("state_o",   int'(state_o),   m_state);
            check("running_o", int'(running_o), int'(m_state == 1));
        end
    end

    int s_incs;
    int s_clrs;
    int s_run;
    int s_clear;
    int s_first;

    // Press the buttons in mask (step, run, clr) for hold cycles, observe for total cycles.
    task automatic drive(input logic [2:0] mask, input int hold, input int total);
        s_incs = 0; s_clrs = 0; s_run = 0; s_clear = 0; s_first = 0;
        // NOTE: inputs change on the falling edge with blocking writes, so the DUT samples stable values.
        if (mask[0]) btn_step = 1'b1;
        if (mask[1]) btn_run  = 1'b1;
        if (mask[2]) btn_clr  = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (inc_o) begin
                s_incs++;
                if (s_first == 0) s_first = k;
            end
            if (clr_o)          s_clrs++;
            if (running_o)      s_run++;
            if (state_o == 2'd2) s_clear++;
            if (k == hold) begin
                if (mask[0]) btn_step = 1'b0;
                if (mask[1]) btn_run  = 1'b0;
                if (mask[2]) btn_clr  = 1'b0;
            end
        end
    endtask

    task automatic start_run(output int found);
        found   = 0;
        btn_run = 1'b1;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(negedge clk);
            if (running_o) found = 1;
            if (k == 6) btn_run = 1'b0;
        end
        btn_run = 1'b0;
    endtask

    initial begin
        int found;
        int incs;
        int first;

        // 1. Reset and single step
        repeat (3) @(negedge clk);
        check("rst_inc",     int'(inc_o),     0);
        check("rst_clr",     int'(clr_o),     0);
        check("rst_running", int'(running_o), 0);
        check("rst_state",   int'(state_o),   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive(3'b001, 10, 16);
        check("s1_latency", s_first, 6);
        check("s1_pulses",  s_incs,  1);
        check("s1_count",   int'(count), 1);

        // 2. Bounce rejection, then a clean press
        for (int k = 0; k < 20; k++) begin
            btn_step = (k % 2 == 0);
            @(negedge clk);
            check("s2_bounce_inc", int'(inc_o), 0);
        end
        btn_step = 1'b0;
        drive(3'b000, 10, 10);
        check("s2_quiet_pulses", s_incs, 0);
        drive(3'b001, 10, 16);
        check("s2_press_pulses", s_incs, 1);
        check("s2_count", int'(count), 2);

        // 3. Clear, auto-run to LIMIT, then run request at LIMIT is ignored
        drive(3'b100, 6, 12);
        check("s3_clr_pulses", s_clrs,  1);
        check("s3_clear_cyc",  s_clear, 1);
        check("s3_cleared",    int'(count), 0);
        drive(3'b010, 6, 40);
        check("s3_run_incs",   s_incs, 5);
        check("s3_run_cycles", s_run,  24);
        check("s3_count",      int'(count), 5);
        check("s3_state",      int'(state_o), 0);
        check("s3_running",    int'(running_o), 0);
        drive(3'b010, 6, 14);
        check("s3_limit_norun", s_run, 0);
        check("s3_limit_count", int'(count), 5);

        // 4. Pause after two increments; step during RUN ignored
        drive(3'b100, 6, 12);
        start_run(found);
        check("s4_started", found, 1);
        btn_step = 1'b1;
        incs = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (inc_o) incs++;
            if (j == 4)  btn_run  = 1'b1;
            if (j == 5)  btn_step = 1'b0;
            if (j == 10) btn_run  = 1'b0;
        end
        check("s4_incs",    incs, 2);
        check("s4_state",   int'(state_o), 0);
        check("s4_running", int'(running_o), 0);
        check("s4_count",   int'(count), 2);

        // 5. Clear and run together from count 3
        drive(3'b001, 6, 12);
        check("s5_pre_count", int'(count), 3);
        drive(3'b110, 6, 14);
        check("s5_clr_pulses", s_clrs,  1);
        check("s5_clear_cyc",  s_clear, 1);
        check("s5_no_run",     s_run,   0);
        check("s5_count",      int'(count), 0);
        check("s5_state",      int'(state_o), 0);

        // 6. Reset one cycle before a tick terminal count
        start_run(found);
        check("s6_started", found, 1);
        incs = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (inc_o) incs++;
            if (j == 2) rst_n = 1'b0;
            if (j == 5) rst_n = 1'b1;
        end
        check("s6_no_inc",  incs, 0);
        check("s6_state",   int'(state_o), 0);
        check("s6_running", int'(running_o), 0);
        start_run(found);
        check("s6_restart", found, 1);
        first = 0;
        for (int j = 1; j <= 8 && first == 0; j++) begin
            @(negedge clk);
            if (inc_o) first = j;
        end
        check("s6_first_tick", first, TICK_DIV);

        // Randomized traffic, checked cycle by cycle against the model
        btn_run = 1'b0;
        repeat (10) @(negedge clk);
        for (int it = 0; it < 300; it++) begin
            int hold;
            hold     = $urandom_range(1, 8);
            btn_step = ($urandom_range(0, 2) == 0);
            btn_run  = ($urandom_range(0, 3) == 0);
            btn_clr  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (hold - 1) @(negedge clk);
        end
        btn_step = 1'b0;
        btn_run  = 1'b0;
        btn_clr  = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
